// File: rtl/sub_mean.sv
// Windowed DC removal: subtracts the last completed window mean from each sample.
// Optional macro SUB_MEAN_SAT_EN saturates the difference instead of wrapping it.
module sub_mean #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_WIN   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] audio_in,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] audio_out,
    output logic [DATA_WIDTH-1:0] mean_out,
    output logic                  win_done,
    output logic                  primed
);

    localparam int AW = DATA_WIDTH + LOG2_WIN;

    typedef enum logic {
        FILL,
        RUN
    } state_t;

    state_t                  state_q;
    logic signed [AW-1:0]    acc_q;
    logic signed [AW-1:0]    sum_d;
    logic [LOG2_WIN-1:0]     cnt_q;
    logic [DATA_WIDTH-1:0]   mean_q;
    logic [DATA_WIDTH-1:0]   mean_d;
    logic [DATA_WIDTH-1:0]   out_d;
    logic [DATA_WIDTH-1:0]   audio_q;
    logic                    valid_q;
    logic                    done_q;
    logic [DATA_WIDTH:0]     diff;
    logic                    last;

    always_comb begin
        sum_d  = acc_q + AW'($signed(audio_in));
        // Bits above the shift point are the floored mean; the sum cannot overflow AW.
        mean_d = sum_d[AW-1:LOG2_WIN];
        diff   = {audio_in[DATA_WIDTH-1], audio_in}
               - {mean_q[DATA_WIDTH-1], mean_q};
        last   = (cnt_q == {LOG2_WIN{1'b1}});
`ifdef SUB_MEAN_SAT_EN
        if (diff[DATA_WIDTH] != diff[DATA_WIDTH-1]) begin
            out_d = diff[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            out_d = diff[DATA_WIDTH-1:0];
        end
`else
        out_d = diff[DATA_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FILL;
            acc_q   <= '0;
            cnt_q   <= '0;
            mean_q  <= '0;
            audio_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            done_q  <= 1'b0;
            if (in_valid) begin
                audio_q <= out_d;
                cnt_q   <= cnt_q + LOG2_WIN'(1);
                if (last) begin
                    acc_q   <= '0;
                    mean_q  <= mean_d;
                    done_q  <= 1'b1;
                    state_q <= RUN;
                end else begin
                    acc_q <= sum_d;
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign audio_out = audio_q;
    assign mean_out  = mean_q;
    assign win_done  = done_q;
    assign primed    = (state_q == RUN);

endmodule

// File: tb/tb_sub_mean.sv
// Directed bench for sub_mean with a 4-sample window.
// Expectations are hand-computed constants per step.
module tb_sub_mean;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] audio_in;
    logic        out_valid;
    logic [15:0] audio_out;
    logic [15:0] mean_out;
    logic        win_done;
    logic        primed;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sub_mean #(
        .DATA_WIDTH(16),
        .LOG2_WIN  (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .audio_in (audio_in),
        .out_valid(out_valid),
        .audio_out(audio_out),
        .mean_out (mean_out),
        .win_done (win_done),
        .primed   (primed)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [15:0] d);
        reset    = r;
        in_valid = v;
        audio_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        audio_in = '0;
        @(posedge clk);
        #1;

        // Reset overrides in_valid
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 16'h1234);
            chk("rst_ov",   {31'd0, out_valid}, 32'd0);
            chk("rst_out",  {16'd0, audio_out}, 32'd0);
            chk("rst_mean", {16'd0, mean_out},  32'd0);
            chk("rst_done", {31'd0, win_done},  32'd0);
            chk("rst_prim", {31'd0, primed},    32'd0);
        end
        step(1'b1, 1'b1, 16'h0005);
        chk("rel_ov",   {31'd0, out_valid}, 32'd1);
        chk("rel_out",  {16'd0, audio_out}, 32'h0005);
        chk("rel_prim", {31'd0, primed},    32'd0);

        // Constant DC
        step(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 16'd100);
            chk("dc1_ov",   {31'd0, out_valid}, 32'd1);
            chk("dc1_out",  {16'd0, audio_out}, 32'd100);
            chk("dc1_done", {31'd0, win_done},  (i == 3) ? 32'd1 : 32'd0);
            chk("dc1_prim", {31'd0, primed},    (i == 3) ? 32'd1 : 32'd0);
        end
        chk("dc1_mean", {16'd0, mean_out}, 32'd100);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 16'd100);
            chk("dc2_out",  {16'd0, audio_out}, 32'd0);
            chk("dc2_done", {31'd0, win_done},  (i == 3) ? 32'd1 : 32'd0);
        end
        chk("dc2_mean", {16'd0, mean_out}, 32'd100);
        step(1'b1, 1'b0, 16'd77);
        chk("idle_ov",   {31'd0, out_valid}, 32'd0);
        chk("idle_out",  {16'd0, audio_out}, 32'd0);
        chk("idle_done", {31'd0, win_done},  32'd0);

        // Negative mean floors toward -inf
        step(1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 16'hFFFF);
        chk("neg_out0", {16'd0, audio_out}, 32'hFFFF);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 16'h0000);
            chk("neg_out", {16'd0, audio_out}, 32'h0000);
        end
        chk("neg_done", {31'd0, win_done}, 32'd1);
        chk("neg_mean", {16'd0, mean_out}, 32'hFFFF);
        step(1'b1, 1'b1, 16'h0000);
        chk("neg_corr", {16'd0, audio_out}, 32'h0001);

        // Saturation vs wrap
        step(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 16'h8000);
            chk("sat_fill", {16'd0, audio_out}, 32'h8000);
        end
        chk("sat_mean", {16'd0, mean_out}, 32'h8000);
        step(1'b1, 1'b1, 16'h7FFF);
`ifdef SUB_MEAN_SAT_EN
        chk("sat_out", {16'd0, audio_out}, 32'h7FFF);
`else
        chk("wrap_out", {16'd0, audio_out}, 32'hFFFF);
`endif

        // Gapped strobes and mid-window reset
        step(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 16'd8);
            chk("gap_ov",  {31'd0, out_valid}, 32'd1);
            chk("gap_out", {16'd0, audio_out}, 32'd8);
            step(1'b1, 1'b0, 16'd8);
            chk("gap_ov0", {31'd0, out_valid}, 32'd0);
            step(1'b1, 1'b0, 16'd8);
            chk("gap_ov0", {31'd0, out_valid}, 32'd0);
        end
        step(1'b0, 1'b0, 16'h0000);
        chk("mid_mean", {16'd0, mean_out}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 16'd20);
            chk("g20_ov",   {31'd0, out_valid}, 32'd1);
            chk("g20_out",  {16'd0, audio_out}, 32'd20);
            chk("g20_done", {31'd0, win_done},  (i == 3) ? 32'd1 : 32'd0);
            step(1'b1, 1'b0, 16'd0);
            chk("g20_ov0",  {31'd0, out_valid}, 32'd0);
            chk("g20_hold", {16'd0, audio_out}, 32'd20);
            step(1'b1, 1'b0, 16'd0);
        end
        chk("g20_mean", {16'd0, mean_out}, 32'd20);
        chk("g20_prim", {31'd0, primed},   32'd1);
        chk("g20_done0", {31'd0, win_done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
